window_gen3x3: RTL and testbench
================================

Name: window_gen3x3

Overview:
Streaming 3x3 window generator, the producer side of the 72-bit window/valid interface consumed by the 3x3 MAC filter.
- Accepts a raster-order 8-bit pixel stream, one pixel per valid cycle.
- Buffers two previous image lines and emits one packed 3x3 neighbourhood per input pixel once a full window exists.
- Valid-mode convolution, no padding.
- Sits between the image source (memory reader/DMA) and the MAC filter.

Parameters:
IMG_WIDTH, 512, pixels per line (>=3)
IMG_HEIGHT, 512, lines per frame (>=3)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
pixel_in  input  8  incoming pixel, unsigned
is_valid_pixel  input  1  pixel_in valid this cycle
pixel_data  output  72  packed 3x3 window, layout below
is_valid_pdata  output  1  pixel_data valid, one-cycle strobe per window
frame_done  output  1  one-cycle pulse with the last window of a frame

Behaviour:
- Reset (async, rst=1): pixel_data=0, is_valid_pdata=0, frame_done=0. Column/row counters and the 3x3 window registers go to 0. Line-buffer RAM is not cleared; stale contents are masked by the row gating.
- Counters: col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1. Both advance only on is_valid_pixel=1.
  - col wraps to 0 at IMG_WIDTH-1 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0, and the next frame starts with no gap cycle.
- Line buffers: two, depth IMG_WIDTH, indexed by col. LB0 holds row r-1 and LB1 holds row r-2.
  - On each accepted pixel at col c: read LB0[c] and LB1[c], write LB1[c]<=LB0[c] and LB0[c]<=pixel_in, in the same cycle with read-before-write semantics.
- Window registers: three rows x three columns. On each accepted pixel:
  - Each row shifts left by one column.
  - The new right column is {LB1[c], LB0[c], pixel_in}.
- Packing: pixel_data[8*i +: 8], i = 3*row_in_window + col_in_window.
  - Row 0 is image row r-2; col 0 is image column c-2.
  - i=0 is the top-left pixel and i=8 is the current input pixel (r,c).
- Output valid: is_valid_pdata=1 exactly one cycle after accepting a pixel with r>=2 and c>=2; otherwise 0.
  - Latency is 1 clk from input to window.
  - Windows never straddle a line wrap.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- pixel_data holds its last value when is_valid_pdata=0.
- Input gaps (is_valid_pixel=0): all state frozen, no output strobe. Gaps are allowed anywhere, including mid-line.
- frame_done: asserted in the same cycle as the is_valid_pdata for window (IMG_HEIGHT-1, IMG_WIDTH-1).
- No backpressure: the downstream MAC accepts every valid cycle.
- Reset mid-frame: the next accepted pixel is treated as (0,0), and no window is emitted until row 2, col 2 of the new frame.

Optional Feature:
Macro SOF_RESYNC_EN.
- Defined: adds input port sof (1 bit). A cycle with is_valid_pixel=1 and sof=1 forces that pixel to position (0,0).
  - Counters restart and the pixel is written as col 0 of row 0.
  - Any partial frame is abandoned, with no frame_done for it.
  - sof without valid is ignored.
- Not defined: no sof port; position is tracked purely by counters from reset.

Test Plan:
1. IMG_WIDTH=5, IMG_HEIGHT=4; pixels 1..20 on consecutive cycles:
   - Exactly 6 windows, first one cycle after pixel 13.
   - First window bytes i0..i8 = 1,2,3,6,7,8,11,12,13.
   - Last window = 8,9,10,13,14,15,18,19,20, with frame_done=1 on that cycle only.
2. Same frame with is_valid_pixel toggling 1,0,1,0: identical 6 windows, each one cycle after its triggering pixel; no strobes in gap cycles.
3. Two back-to-back frames (second frame pixels 101..120):
   - Second frame first window = 101,102,103,106,107,108,111,112,113.
   - No window mixes data from both frames; 12 windows total.
4. Assert rst after pixel 14 of frame 1, then send 1..20:
   - All outputs 0 during reset.
   - Output matches scenario 1 exactly, with no stale window.
5. With SOF_RESYNC_EN: send pixels 1..7, then sof=1 with pixels 1..20:
   - Output identical to scenario 1; frame_done once.
6. Line wrap check (5x4 frame): no is_valid_pdata after pixels 11, 12, 16 or 17 (cols 0 and 1 of rows 2 and 3).

Source files
------------

// File: rtl/window_gen3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window.
// Optional SOF_RESYNC_EN adds a sof input that forces a pixel to (0,0).
module window_gen3x3 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SOF_RESYNC_EN
  input  logic        sof,
`endif
  input  logic [7:0]  pixel_in,
  input  logic        is_valid_pixel,
  output logic [71:0] pixel_data,
  output logic        is_valid_pdata,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_q, col, col_nxt;
  logic [RW-1:0] row_q, row, row_nxt;
  logic [7:0]    lb0 [IMG_WIDTH];
  logic [7:0]    lb1 [IMG_WIDTH];
  logic [7:0]    lb0_rd, lb1_rd;
  logic [8:0][7:0] win_q, win_nxt;
  logic          win_ok;
  logic          last_px;

  // Effective position of the current pixel (sof overrides counters)
  always_comb begin
    col = col_q;
    row = row_q;
`ifdef SOF_RESYNC_EN
    if (sof) begin
      col = '0;
      row = '0;
    end
`endif
  end

  always_comb begin
    col_nxt = col + CW'(1);
    row_nxt = row;
    if (col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row == ROW_LAST) ? '0 : row + RW'(1);
    end
  end

  assign lb0_rd  = lb0[col];
  assign lb1_rd  = lb1[col];
  assign win_ok  = (row >= RW'(2)) && (col >= CW'(2));
  assign last_px = (row == ROW_LAST) && (col == COL_LAST);

  always_comb begin
    win_nxt = win_q;
    for (int k = 0; k < 3; k++) begin
      win_nxt[3*k]   = win_q[3*k+1];
      win_nxt[3*k+1] = win_q[3*k+2];
    end
    win_nxt[2] = lb1_rd;
    win_nxt[5] = lb0_rd;
    win_nxt[8] = pixel_in;
  end

  // Line buffers are plain RAM: read-before-write, never reset
  always_ff @(posedge clk) begin
    if (is_valid_pixel) begin
      lb1[col] <= lb0_rd;
      lb0[col] <= pixel_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q          <= '0;
      row_q          <= '0;
      win_q          <= '0;
      pixel_data     <= '0;
      is_valid_pdata <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      is_valid_pdata <= is_valid_pixel && win_ok;
      frame_done     <= is_valid_pixel && last_px;
      if (is_valid_pixel) begin
        col_q <= col_nxt;
        row_q <= row_nxt;
        win_q <= win_nxt;
        if (win_ok)
          pixel_data <= win_nxt;
      end
    end
  end

endmodule

// File: tb/tb_window_gen3x3.sv
// Directed scoreboard bench for window_gen3x3 on a 5x4 frame.
// Define SOF_RESYNC_EN to also exercise the sof resync scenario.
module tb_window_gen3x3;

  localparam int W = 5;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pixel_in = '0;
  logic        is_valid_pixel = 1'b0;
  logic [71:0] pixel_data;
  logic        is_valid_pdata;
  logic        frame_done;
`ifdef SOF_RESYNC_EN
  logic        sof = 1'b0;
`endif

  window_gen3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef SOF_RESYNC_EN
    .sof            (sof),
`endif
    .pixel_in       (pixel_in),
    .is_valid_pixel (is_valid_pixel),
    .pixel_data     (pixel_data),
    .is_valid_pdata (is_valid_pdata),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  logic [7:0]  img [H][W];
  int          mr, mc;
  bit          pending;
  logic [71:0] q_data [$];
  bit          q_fd [$];
  logic [71:0] obs [$];
  logic [71:0] last_pd;
  int          checks, errors, nwin, nfd;

  localparam logic [71:0] S1_FIRST = 72'h0d0c0b080706030201;
  localparam logic [71:0] S1_LAST  = 72'h1413120f0e0d0a0908;
  localparam logic [71:0] S3_FIRST = 72'h71706f6c6b6a676665;

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_out();
    logic [71:0] e;
    bit          fd;
    if (pending) begin
      chk("strobe", 72'(is_valid_pdata), 72'(1));
      if (q_data.size() == 0) begin
        chk("sb_empty", 72'(0), 72'(1));
      end else begin
        e  = q_data.pop_front();
        fd = q_fd.pop_front();
        chk("window", pixel_data, e);
        chk("frame_done", 72'(frame_done), 72'(fd));
        last_pd = e;
      end
      if (is_valid_pdata === 1'b1) begin
        nwin++;
        obs.push_back(pixel_data);
      end
      if (frame_done === 1'b1) nfd++;
      pending = 0;
    end else begin
      chk("no_strobe", 72'(is_valid_pdata), 72'(0));
      chk("no_fd", 72'(frame_done), 72'(0));
      chk("hold", pixel_data, last_pd);
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] p, input bit s);
    logic [71:0] e;
    @(negedge clk);
    check_out();
    is_valid_pixel = v;
    pixel_in       = p;
`ifdef SOF_RESYNC_EN
    sof            = s;
`endif
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        for (int i = 0; i < 9; i++)
          e[8*i +: 8] = img[mr-2+i/3][mc-2+i%3];
        q_data.push_back(e);
        q_fd.push_back(mr == H-1 && mc == W-1);
        pending = 1;
      end
      if (mc == W-1) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_out();
    rst = 1'b1;
    is_valid_pixel = 1'b0;
    #1;
    chk("rst_pdata", pixel_data, 72'(0));
    chk("rst_valid", 72'(is_valid_pdata), 72'(0));
    chk("rst_fd", 72'(frame_done), 72'(0));
    q_data.delete();
    q_fd.delete();
    pending = 0;
    last_pd = '0;
    mr = 0;
    mc = 0;
    @(negedge clk);
    chk("rst_pdata2", pixel_data, 72'(0));
    chk("rst_valid2", 72'(is_valid_pdata), 72'(0));
    rst = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int k = 0; k < W*H; k++) begin
      cyc(1'b1, 8'(base + k), 1'b0);
      if (gaps) cyc(1'b0, 8'hff, 1'b0);
    end
  endtask

  task automatic clear_stats();
    nwin = 0;
    nfd  = 0;
    obs.delete();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    pending = 0;
    last_pd = '0;
    mr = 0;
    mc = 0;
    clear_stats();
    do_reset();

    // 1: plain frame
    send_frame(1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("s1_count", 72'(nwin), 72'(6));
    chk("s1_fd_count", 72'(nfd), 72'(1));
    chk("s1_first", obs[0], S1_FIRST);
    chk("s1_last", obs[5], S1_LAST);

    // 2: valid toggling 1,0,1,0
    clear_stats();
    send_frame(1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("s2_count", 72'(nwin), 72'(6));
    chk("s2_first", obs[0], S1_FIRST);
    chk("s2_last", obs[5], S1_LAST);

    // 3: back-to-back frames
    clear_stats();
    send_frame(1, 1'b0);
    send_frame(101, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("s3_count", 72'(nwin), 72'(12));
    chk("s3_fd_count", 72'(nfd), 72'(2));
    chk("s3_first2", obs[6], S3_FIRST);

    // 4: reset mid-frame
    for (int k = 1; k <= 14; k++) cyc(1'b1, 8'(k), 1'b0);
    do_reset();
    clear_stats();
    send_frame(1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("s4_count", 72'(nwin), 72'(6));
    chk("s4_first", obs[0], S1_FIRST);
    chk("s4_last", obs[5], S1_LAST);

`ifdef SOF_RESYNC_EN
    // 5: sof resync abandons a partial frame
    for (int k = 1; k <= 7; k++) cyc(1'b1, 8'(k), 1'b0);
    clear_stats();
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'd1, 1'b1);
    for (int k = 2; k <= 20; k++) cyc(1'b1, 8'(k), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("s5_count", 72'(nwin), 72'(6));
    chk("s5_fd_count", 72'(nfd), 72'(1));
    chk("s5_first", obs[0], S1_FIRST);
    chk("s5_last", obs[5], S1_LAST);
`endif

    cyc(1'b0, 8'h00, 1'b0);
    chk("sb_drained", 72'(q_data.size()), 72'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
